zigzag_block_assembler: RTL and testbench
=========================================

// Module: zigzag_block_assembler
// PURPOSE
//  Parametrised successor to the single-buffer zig-zag table builder. It accepts (run, coefficient)
//  symbols from the entropy decoder and places each coefficient at its de-zig-zagged raster position
//  in an 8x8 block; every block starts from all-zero. It ping-pongs between BANKS block buffers and
//  hands complete 64-entry blocks, in raster order, to dequant/IDCT over a valid/ready handshake.
//  It also adds end-of-block (EOB) handling and overflow detection.
// PARAMETERS
//  COEF_W  8  coefficient width, bits (treated as opaque data)
//  RUN_W   4  run-length field width (JPEG: 4, max run 15)
//  BANKS   2  number of block buffers; legal values 1 or 2 (elaboration error otherwise)
// PORTS
//  clk          in   1          rising-edge clock
//  rst          in   1          reset: asynchronous, active-low
//  in_valid     in   1          symbol present
//  in_ready     out  1          symbol is accepted when in_valid and in_ready are both high
//  in_run       in   RUN_W      count of zero coefficients that precede in_coef
//  in_coef      in   COEF_W     non-zero (or ZRL zero) coefficient
//  in_eob       in   1          EOB symbol: close the block; in_run and in_coef are ignored
//  out_valid    out  1          a complete block is on out_block
//  out_ready    in   1          consumer takes the block on out_valid && out_ready
//  out_block    out  64*COEF_W  raster-order block; entry k is at [k*COEF_W +: COEF_W]
//  err_overflow out  1          one-cycle pulse: pos+run > 63 on an accepted symbol
// BEHAVIOUR
//  Reset (rst low, asynchronous):
//   - all banks are zeroed; pos=0; write and read bank pointers = 0
//   - out_valid=0, err_overflow=0
//   - in_ready=1 from the first edge after rst is released
//   - a partially filled block is discarded
//  Write side (on an accepted symbol, with pos = 6-bit zig-zag position, initially 0):
//   - tgt = {1'b0,pos} + in_run, computed 7 bits wide
//   - in_eob=1: no write; the block closes
//   - tgt<=63: bank[wr][ZZ[tgt]] <= in_coef; pos <= tgt+1 (mod 64)
//       - if tgt==63 the block closes
//       - run=15 with coef=0 (ZRL) needs no special case
//   - tgt>63: no write; err_overflow=1 on the next cycle; the block closes
//       - skipped positions stay zero
//  Block close:
//   - the bank is marked full; pos <= 0; wr <= wr+1 (mod BANKS)
//   - out_valid rises on the cycle after the closing edge (registered; latency 1)
//  in_ready = !full[wr]
//   - BANKS=1: low from block close until that block is released
//   - BANKS=2: low only when both banks are full
//  Read side:
//   - out_valid = full[rd]
//   - out_block is driven from bank[rd] and is stable while out_valid && !out_ready
//   - release (out_valid && out_ready): full[rd] <= 0; bank[rd] zeroed at that same edge;
//     rd <= rd+1 (mod BANKS)
//  Simultaneous close and release on different banks (BANKS=2):
//   - both take effect; no bubble
//  BANKS=1, release edge:
//   - in_ready rises the cycle after the release
//   - the next symbol writes into the freshly zeroed bank
//  Writes never target a full bank, and reads never see a partial bank.
// STRUCTURE
//  Shared package (jpeg_pkg): ZZ_ORDER constant (64 x 6-bit zig-zag-to-raster map) and BLK_SZ=64.
//  Sub-module zigzag_lut:
//   - combinational 6-bit index in, 6-bit raster index out
//   - reads ZZ_ORDER; reused by the encoder path
//  Top level:
//   - bank flop arrays, with per-bank clear
//   - pos / wr / rd counters and full[] flags
//   - the error pulse register
//   - no FSM beyond the per-bank full flags
// TESTING
//  1. Reset, then {run0,c=5},{run0,c=7},EOB.
//     -> out_valid 1 cycle after EOB; raster[0]=5, raster[1]=7, all other entries 0.
//  2. {run2,c=9} as the first symbol -> raster[ZZ[2]=8]=9; pos=3.
//     Then 61 x {run0,c=k}: position 63 fills and the block closes without EOB.
//  3. BANKS=2: stream 3 back-to-back blocks with out_ready=0.
//     -> in_ready drops after the 2nd block closes.
//     Raise out_ready -> blocks emerge in order; every block after the first has no stale data.
//  4. pos=60, then {run5,c=3}.
//     -> err_overflow pulses once; no write; block closes with raster[ZZ[60..63]]=0.
//  5. BANKS=1: hold out_ready=0 for 10 cycles after a block.
//     -> in_ready=0 and out_block stable throughout; release -> in_ready=1 next cycle.
//  6. Assert rst mid-block (pos=20) and while out_valid=1.
//     -> out_valid=0 immediately; the next block starts at pos 0 with all banks zero.

Source files
------------

// File: rtl/jpeg_pkg.sv
// Shared JPEG definitions.
//   BLK_SZ   : coefficients per 8x8 block
//   zz_idx_t : 6-bit index into a block (zig-zag or raster)
//   ZZ_ORDER : zig-zag position -> raster position map (entry i = raster index of zig-zag i)
package jpeg_pkg;

  localparam int BLK_SZ = 64;

  typedef logic [5:0] zz_idx_t;

  localparam zz_idx_t ZZ_ORDER [BLK_SZ] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/zigzag_lut.sv
// Zig-zag to raster index lookup (purely combinational).
// Ports:
//   zz_idx     in  6  zig-zag scan position
//   raster_idx out 6  corresponding raster (row*8+col) position
module zigzag_lut
  import jpeg_pkg::*;
(
  input  logic [5:0] zz_idx,
  output logic [5:0] raster_idx
);

  assign raster_idx = ZZ_ORDER[zz_idx];

endmodule

// File: rtl/zigzag_block_assembler.sv
// Builds 8x8 coefficient blocks from (run, coefficient) symbols and hands
// complete blocks out in raster order. One or two block buffers ping-pong
// between the write (symbol) side and the read (block) side.
// Ports:
//   clk          in   1           rising-edge clock
//   rst          in   1           asynchronous reset, active low
//   in_valid     in   1           symbol present
//   in_ready     out  1           symbol accepted on in_valid && in_ready
//   in_run       in   RUN_W       zeros preceding in_coef
//   in_coef      in   COEF_W      coefficient value
//   in_eob       in   1           end-of-block symbol (run/coef ignored)
//   out_valid    out  1           complete block on out_block
//   out_ready    in   1           block taken on out_valid && out_ready
//   out_block    out  64*COEF_W   raster-order block, entry k at [k*COEF_W +: COEF_W]
//   err_overflow out  1           one-cycle pulse after a symbol ran past position 63
module zigzag_block_assembler
  import jpeg_pkg::*;
#(
  parameter int COEF_W = 8,
  parameter int RUN_W  = 4,
  parameter int BANKS  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [RUN_W-1:0]         in_run,
  input  logic [COEF_W-1:0]        in_coef,
  input  logic                     in_eob,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [64*COEF_W-1:0]     out_block,
  output logic                     err_overflow
);

  if (BANKS != 1 && BANKS != 2) begin : g_bad_banks
    $error("zigzag_block_assembler: BANKS must be 1 or 2");
  end

  // Storage is always sized for two buffers. With BANKS=1 both pointers stay
  // at 0, so buffer 1 is never written and only ever holds zero.
  localparam int NB = 2;

  zz_idx_t           pos;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [NB-1:0]     full;
  logic [COEF_W-1:0] bank [NB][BLK_SZ];
  logic [6:0]        tgt;
  zz_idx_t           raster_idx;
  logic              accept;
  logic              sym_write;
  logic              sym_ovf;
  logic              blk_close;
  logic              blk_release;
  logic              err_p1;

  function automatic logic next_ptr(input logic p);
    return (BANKS == 2) ? ~p : 1'b0;
  endfunction

  // Target computed one bit wider than pos so a run past 63 is visible in tgt[6].
  assign tgt         = {1'b0, pos} + 7'(in_run);
  assign in_ready    = !full[wr_ptr];
  assign out_valid   = full[rd_ptr];
  assign accept      = in_valid && in_ready;
  assign sym_write   = accept && !in_eob && !tgt[6];
  assign sym_ovf     = accept && !in_eob && tgt[6];
  assign blk_close   = accept && (in_eob || tgt[6] || (tgt[5:0] == 6'd63));
  assign blk_release = out_valid && out_ready;
  assign err_overflow = err_p1;

  zigzag_lut u_lut (
    .zz_idx     (tgt[5:0]),
    .raster_idx (raster_idx)
  );

  // Control: position counter, bank pointers, full flags, error pulse.
  // A close always targets bank[wr] (not full) and a release bank[rd] (full),
  // so the two can never hit the same bank in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      full   <= '0;
      err_p1 <= 1'b0;
    end else begin
      err_p1 <= sym_ovf;
      if (blk_close) begin
        pos    <= '0;
        wr_ptr <= next_ptr(wr_ptr);
      end else if (sym_write) begin
        pos <= tgt[5:0] + 6'd1;
      end
      if (blk_release) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      for (int b = 0; b < NB; b++) begin
        if (blk_close && (wr_ptr == 1'(b))) begin
          full[b] <= 1'b1;
        end else if (blk_release && (rd_ptr == 1'(b))) begin
          full[b] <= 1'b0;
        end
      end
    end
  end

  // Block buffers: a released bank is zeroed at the release edge so the next
  // block it receives starts from all-zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < NB; b++) begin
        for (int k = 0; k < BLK_SZ; k++) begin
          bank[b][k] <= '0;
        end
      end
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (blk_release && (rd_ptr == 1'(b))) begin
          for (int k = 0; k < BLK_SZ; k++) begin
            bank[b][k] <= '0;
          end
        end else if (sym_write && (wr_ptr == 1'(b))) begin
          bank[b][raster_idx] <= in_coef;
        end
      end
    end
  end

  always_comb begin
    out_block = '0;
    for (int k = 0; k < BLK_SZ; k++) begin
      out_block[k*COEF_W +: COEF_W] = bank[rd_ptr][k];
    end
  end

endmodule

// File: tb/tb_zigzag_block_assembler.sv
module tb_zigzag_block_assembler;

  localparam int COEF_W = 8;
  localparam int RUN_W  = 4;
  localparam int BW     = 64*COEF_W;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  int zzt [64] = '{
    0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
   12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
   35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
   58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63 };

  logic              v2, ir2, eob2, ov2, ordy2, err2;
  logic [RUN_W-1:0]  run2;
  logic [COEF_W-1:0] coef2;
  logic [BW-1:0]     blk2;

  logic              v1, ir1, eob1, ov1, ordy1, err1;
  logic [RUN_W-1:0]  run1;
  logic [COEF_W-1:0] coef1;
  logic [BW-1:0]     blk1;

  zigzag_block_assembler #(.COEF_W(COEF_W), .RUN_W(RUN_W), .BANKS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(ir2), .in_run(run2),
    .in_coef(coef2), .in_eob(eob2), .out_valid(ov2), .out_ready(ordy2),
    .out_block(blk2), .err_overflow(err2));

  zigzag_block_assembler #(.COEF_W(COEF_W), .RUN_W(RUN_W), .BANKS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .in_run(run1),
    .in_coef(coef1), .in_eob(eob1), .out_valid(ov1), .out_ready(ordy1),
    .out_block(blk1), .err_overflow(err1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send2(input int run, input int coef, input bit eob);
    int n;
    n = 0;
    v2 = 1'b1; run2 = run[RUN_W-1:0]; coef2 = coef[COEF_W-1:0]; eob2 = eob;
    while (ir2 !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL send2_timeout: in_ready=%b, required 1", ir2);
    end
    @(posedge clk); #1;
    v2 = 1'b0; run2 = '0; coef2 = '0; eob2 = 1'b0;
  endtask

  task automatic send1(input int run, input int coef, input bit eob);
    int n;
    n = 0;
    v1 = 1'b1; run1 = run[RUN_W-1:0]; coef1 = coef[COEF_W-1:0]; eob1 = eob;
    while (ir1 !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL send1_timeout: in_ready=%b, required 1", ir1);
    end
    @(posedge clk); #1;
    v1 = 1'b0; run1 = '0; coef1 = '0; eob1 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ov2 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", ov2); end
    checks++;
    if (err2 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", err2); end
    checks++;
    if (blk2 !== '0) begin errors++; $display("FAIL reset_block: got %h, required 0", blk2); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ir2 !== 1'b1 || ir1 !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b/%b, required 1/1", ir2, ir1);
    end
  endtask

  task automatic test_basic;
    logic [BW-1:0] expb;
    send2(0, 5, 1'b0);
    send2(0, 7, 1'b0);
    checks++;
    if (ov2 !== 1'b0) begin errors++; $display("FAIL basic_no_early_valid: got %b, required 0", ov2); end
    send2(0, 0, 1'b1);
    checks++;
    if (ov2 !== 1'b1) begin errors++; $display("FAIL basic_valid_after_eob: got %b, required 1", ov2); end
    expb = '0;
    expb[0*COEF_W +: COEF_W] = 8'd5;
    expb[1*COEF_W +: COEF_W] = 8'd7;
    checks++;
    if (blk2 !== expb) begin errors++; $display("FAIL basic_block: got %h, required %h", blk2, expb); end
    ordy2 = 1'b1; @(posedge clk); #1; ordy2 = 1'b0;
    checks++;
    if (ov2 !== 1'b0) begin errors++; $display("FAIL basic_release: got %b, required 0", ov2); end
  endtask

  task automatic test_full_block;
    logic [BW-1:0] expb;
    send2(2, 9, 1'b0);
    for (int k = 1; k <= 61; k++) begin
      if (k == 61) begin
        checks++;
        if (ov2 !== 1'b0) begin errors++; $display("FAIL full_no_early_valid: got %b, required 0", ov2); end
      end
      send2(0, k, 1'b0);
    end
    checks++;
    if (ov2 !== 1'b1) begin errors++; $display("FAIL full_close_at_63: got %b, required 1", ov2); end
    expb = '0;
    expb[8*COEF_W +: COEF_W] = 8'd9;
    for (int i = 0; i <= 60; i++) expb[zzt[3+i]*COEF_W +: COEF_W] = 8'(i + 1);
    checks++;
    if (blk2 !== expb) begin errors++; $display("FAIL full_block: got %h, required %h", blk2, expb); end
    ordy2 = 1'b1; @(posedge clk); #1; ordy2 = 1'b0;
    checks++;
    if (ov2 !== 1'b0) begin errors++; $display("FAIL full_release: got %b, required 0", ov2); end
  endtask

  task automatic test_ping_pong;
    logic [BW-1:0] expb;
    ordy2 = 1'b0;
    send2(0, 11, 1'b0); send2(0, 12, 1'b0); send2(0, 0, 1'b1);
    checks++;
    if (ir2 !== 1'b1 || ov2 !== 1'b1) begin
      errors++; $display("FAIL pp_one_full: in_ready=%b out_valid=%b, required 1/1", ir2, ov2);
    end
    send2(0, 21, 1'b0); send2(0, 0, 1'b1);
    checks++;
    if (ir2 !== 1'b0) begin errors++; $display("FAIL pp_both_full: in_ready=%b, required 0", ir2); end
    expb = '0; expb[0 +: COEF_W] = 8'd11; expb[COEF_W +: COEF_W] = 8'd12;
    checks++;
    if (blk2 !== expb) begin errors++; $display("FAIL pp_block_a: got %h, required %h", blk2, expb); end
    ordy2 = 1'b1; @(posedge clk); #1; ordy2 = 1'b0;
    expb = '0; expb[0 +: COEF_W] = 8'd21;
    checks++;
    if (ov2 !== 1'b1 || blk2 !== expb || ir2 !== 1'b1) begin
      errors++; $display("FAIL pp_block_b: valid=%b ready=%b got %h, required 1/1 %h", ov2, ir2, blk2, expb);
    end
    send2(1, 31, 1'b0); send2(0, 0, 1'b1);
    ordy2 = 1'b1; @(posedge clk); #1; ordy2 = 1'b0;
    expb = '0; expb[1*COEF_W +: COEF_W] = 8'd31;
    checks++;
    if (ov2 !== 1'b1 || blk2 !== expb) begin
      errors++; $display("FAIL pp_block_c: valid=%b got %h, required 1 %h", ov2, blk2, expb);
    end
    ordy2 = 1'b1; @(posedge clk); #1; ordy2 = 1'b0;
    checks++;
    if (ov2 !== 1'b0) begin errors++; $display("FAIL pp_drained: got %b, required 0", ov2); end
  endtask

  task automatic test_back_to_back;
    logic [BW-1:0] expb;
    send2(0, 41, 1'b0); send2(0, 0, 1'b1);
    send2(0, 51, 1'b0);
    v2 = 1'b1; eob2 = 1'b1; ordy2 = 1'b1;
    @(posedge clk); #1;
    v2 = 1'b0; eob2 = 1'b0; ordy2 = 1'b0;
    expb = '0; expb[0 +: COEF_W] = 8'd51;
    checks++;
    if (ov2 !== 1'b1 || ir2 !== 1'b1 || blk2 !== expb) begin
      errors++; $display("FAIL b2b_close_and_release: valid=%b ready=%b got %h, required 1/1 %h", ov2, ir2, blk2, expb);
    end
    ordy2 = 1'b1; @(posedge clk); #1; ordy2 = 1'b0;
    checks++;
    if (ov2 !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b, required 0", ov2); end
  endtask

  task automatic test_overflow;
    logic [BW-1:0] expb;
    send2(15, 1, 1'b0); send2(15, 2, 1'b0); send2(15, 3, 1'b0); send2(11, 4, 1'b0);
    checks++;
    if (err2 !== 1'b0 || ov2 !== 1'b0) begin
      errors++; $display("FAIL ovf_before: err=%b valid=%b, required 0/0", err2, ov2);
    end
    send2(5, 3, 1'b0);
    checks++;
    if (err2 !== 1'b1 || ov2 !== 1'b1) begin
      errors++; $display("FAIL ovf_pulse: err=%b valid=%b, required 1/1", err2, ov2);
    end
    @(posedge clk); #1;
    checks++;
    if (err2 !== 1'b0) begin errors++; $display("FAIL ovf_single_pulse: got %b, required 0", err2); end
    expb = '0;
    expb[5*COEF_W +: COEF_W]  = 8'd1;
    expb[28*COEF_W +: COEF_W] = 8'd2;
    expb[51*COEF_W +: COEF_W] = 8'd3;
    expb[54*COEF_W +: COEF_W] = 8'd4;
    checks++;
    if (blk2 !== expb) begin errors++; $display("FAIL ovf_block: got %h, required %h", blk2, expb); end
    ordy2 = 1'b1; @(posedge clk); #1; ordy2 = 1'b0;
  endtask

  task automatic test_single_bank;
    logic [BW-1:0] expb;
    ordy1 = 1'b0;
    send1(0, 77, 1'b0); send1(0, 0, 1'b1);
    checks++;
    if (ov1 !== 1'b1 || ir1 !== 1'b0) begin
      errors++; $display("FAIL sb_closed: valid=%b ready=%b, required 1/0", ov1, ir1);
    end
    expb = '0; expb[0 +: COEF_W] = 8'd77;
    v1 = 1'b1; run1 = 4'd1; coef1 = 8'd99; eob1 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (ir1 !== 1'b0 || ov1 !== 1'b1 || blk1 !== expb) begin
        errors++; $display("FAIL sb_stall_%0d: ready=%b valid=%b got %h, required 0/1 %h", c, ir1, ov1, blk1, expb);
      end
    end
    ordy1 = 1'b1; @(posedge clk); #1; ordy1 = 1'b0;
    checks++;
    if (ir1 !== 1'b1 || ov1 !== 1'b0) begin
      errors++; $display("FAIL sb_release: ready=%b valid=%b, required 1/0", ir1, ov1);
    end
    @(posedge clk); #1;
    v1 = 1'b0; run1 = '0; coef1 = '0;
    send1(0, 0, 1'b1);
    expb = '0; expb[1*COEF_W +: COEF_W] = 8'd99;
    checks++;
    if (ov1 !== 1'b1 || blk1 !== expb) begin
      errors++; $display("FAIL sb_fresh_bank: valid=%b got %h, required 1 %h", ov1, blk1, expb);
    end
    ordy1 = 1'b1; @(posedge clk); #1; ordy1 = 1'b0;
  endtask

  task automatic test_reset_mid_block;
    logic [BW-1:0] expb;
    send2(0, 66, 1'b0); send2(0, 0, 1'b1);
    for (int k = 0; k < 20; k++) send2(0, 1, 1'b0);
    checks++;
    if (ov2 !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b, required 1", ov2); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ov2 !== 1'b0 || blk2 !== '0) begin
      errors++; $display("FAIL rst_async_clear: valid=%b got %h, required 0 0", ov2, blk2);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ir2 !== 1'b1 || ov1 !== 1'b0) begin
      errors++; $display("FAIL rst_after: ready=%b valid1=%b, required 1/0", ir2, ov1);
    end
    send2(0, 88, 1'b0); send2(0, 0, 1'b1);
    expb = '0; expb[0 +: COEF_W] = 8'd88;
    checks++;
    if (ov2 !== 1'b1 || blk2 !== expb) begin
      errors++; $display("FAIL rst_new_block: valid=%b got %h, required 1 %h", ov2, blk2, expb);
    end
    ordy2 = 1'b1; @(posedge clk); #1; ordy2 = 1'b0;
    checks++;
    if (ov2 !== 1'b0) begin errors++; $display("FAIL rst_drained: got %b, required 0", ov2); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0;
    v2 = 1'b0; run2 = '0; coef2 = '0; eob2 = 1'b0; ordy2 = 1'b0;
    v1 = 1'b0; run1 = '0; coef1 = '0; eob1 = 1'b0; ordy1 = 1'b0;
    test_reset;
    test_basic;
    test_full_block;
    test_ping_pong;
    test_back_to_back;
    test_overflow;
    test_single_bank;
    test_reset_mid_block;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
